chip8_timer_ctrl: RTL
=====================

Name: chip8_timer_ctrl

Overview:
- Owns the CHIP-8 delay timer (DT) and sound timer (ST).
- Derives the 60 Hz decrement tick from the single CPU clock with a prescaler.
- Arbitrates CPU writes against tick decrements and gives the CPU a registered read-back port.
- Drives the sound enable (and optionally a square-wave tone) for the audio block.

Parameters:
- CLK_HZ, 50000000, CPU clock frequency in Hz.
- TICK_HZ, 60, timer decrement rate. DIV = CLK_HZ/TICK_HZ, integer division. DIV must be >= 2.
- TONE_HZ, 440, buzzer frequency. HALF = CLK_HZ/(2*TONE_HZ). HALF must be >= 1. Used only with TIMER_TONE_EN.

Ports:
- cpu_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pause  in  1  freeze prescaler and both timers (CPU halted/debug).
- wr_en  in  1  write strobe, one-cycle.
- wr_sel  in  1  0 = DT, 1 = ST.
- wr_data  in  8  value to load.
- rd_en  in  1  read strobe.
- rd_sel  in  1  0 = DT, 1 = ST.
- rd_data  out  8  registered read data.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- tick  out  1  one-cycle 60 Hz pulse.
- dt_expired  out  1  one-cycle pulse when DT counts 1 -> 0.
- sound_on  out  1  high while ST != 0.
- tone_out  out  1  square wave (TIMER_TONE_EN only).

Behaviour:
- Clocking: one clock (cpu_clk); reset is synchronous and active-high. All state changes on rising cpu_clk.
- Reset values: prescaler = 0, DT = 0, ST = 0, rd_data = 0, rd_valid = 0, tick = 0, dt_expired = 0, sound_on = 0, tone_out = 0.
- Reset mid-operation overrides everything in that cycle, including any coincident wr_en or rd_en.
- Prescaler: counts 0..DIV-1.
  - When count == DIV-1 and !pause: count wraps to 0 and tick is registered high for exactly one cycle.
  - pause holds the count and suppresses tick.
  - First tick after reset arrives DIV cycles after reset deasserts.
- Decrement: on the edge where tick = 1, each timer that is nonzero decrements by 1.
  - Timers saturate at 0; there is no wrap to 255.
  - pause also blocks decrement.
- Write: wr_en loads wr_data into the selected timer on that edge.
  - Same edge as tick, same timer: the write wins. The loaded value is not decremented that edge.
  - The other timer still decrements normally.
  - A write while paused takes effect.
  - Writing 0 is legal and never produces dt_expired.
- Read: rd_en samples the selected timer value before that edge's update.
  - rd_data is presented the next cycle with rd_valid = 1 for one cycle.
  - rd_data holds its value until the next read.
  - Back-to-back reads are allowed, one per cycle.
- dt_expired: pulses in the cycle after a tick-driven DT transition 1 -> 0. A write to DT cannot produce it.
- sound_on: high whenever the ST register != 0, with no extra latency.
  - Loading ST = 1 gives sound_on high for the remaining time until the next tick.
- Widths: the prescaler counter is $clog2(DIV) bits. Timers are 8 bits unsigned. No wider arithmetic.

Optional Feature:
- Macro: TIMER_TONE_EN.
- Defined:
  - A half-period counter runs 0..HALF-1 while sound_on is high; tone_out toggles at each wrap.
  - When sound_on is low, the counter is held at 0 and tone_out is forced to 0.
  - The first toggle occurs HALF cycles after sound_on rises.
  - pause does not stop the tone.
- Undefined:
  - No tone counter is built; tone_out is tied to 0.
  - The audio block uses sound_on as a level enable.

Test Plan (CLK_HZ=600, TICK_HZ=60 -> DIV=10; TONE_HZ=60 -> HALF=5):
- Reset, then idle 30 cycles -> tick pulses at cycles 10, 20, 30 after reset release. All other outputs stay 0.
- Write DT=3, then run -> DT reads 2, 1, 0 after successive ticks. dt_expired pulses once, one cycle after the 1 -> 0 tick. DT stays 0 after later ticks (no wrap).
- Write ST=5 on the same cycle as a tick, with DT=7 -> ST reads 5 and DT reads 6 afterwards. sound_on stays high for exactly 5 further ticks, then drops.
- Assert pause for 25 cycles with DT=4 -> no tick and DT stays 4. After release, the next tick comes after the remaining prescaler count, not after a full DIV.
- rd_en with rd_sel=1 on the tick edge, ST=2 -> next cycle rd_data = 2, rd_valid = 1 for one cycle. A following read returns 1.
- With TIMER_TONE_EN, write ST=2 -> tone_out toggles every 5 cycles while sound_on is high. It returns to 0 and stays there once ST reaches 0.

Source files
------------

// File: rtl/chip8_timer_ctrl.sv
// chip8_timer_ctrl
// ----------------
// CHIP-8 delay timer (DT) and sound timer (ST) block. A prescaler divides
// cpu_clk down to the 60 Hz decrement tick. CPU writes share the timer
// registers with the tick decrements, and a registered read-back port is
// provided. Sound enable is a level output, and a square-wave tone can
// optionally be generated as well.
//
// Optional build macro: TIMER_TONE_EN
//   defined   -> half-period counter drives a square wave on tone_out
//   undefined -> no tone hardware, tone_out tied to 0
//
// Parameters:
//   CLK_HZ   cpu_clk frequency in Hz
//   TICK_HZ  timer decrement rate, DIV = CLK_HZ/TICK_HZ (must be >= 2)
//   TONE_HZ  buzzer frequency, HALF = CLK_HZ/(2*TONE_HZ) (must be >= 1)
//
// Ports:
//   cpu_clk     in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   pause       in   freezes prescaler and both timers
//   wr_en       in   one-cycle write strobe
//   wr_sel      in   0 = DT, 1 = ST
//   wr_data     in   [7:0] value to load
//   rd_en       in   read strobe
//   rd_sel      in   0 = DT, 1 = ST
//   rd_data     out  [7:0] registered read data, held until the next read
//   rd_valid    out  one-cycle pulse, rd_data valid
//   tick        out  one-cycle 60 Hz pulse
//   dt_expired  out  one-cycle pulse after a tick takes DT from 1 to 0
//   sound_on    out  high while ST != 0
//   tone_out    out  square wave while sound_on (tone build only)

module chip8_timer_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 60,
    parameter int TONE_HZ = 440
) (
    input  logic       cpu_clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic       rd_sel,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       tick,
    output logic       dt_expired,
    output logic       sound_on,
    output logic       tone_out
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    // Reject parameter sets the counters cannot represent.
    generate
        if (DIV < 2) begin : g_div_check
            $error("chip8_timer_ctrl: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (CLK_HZ / (2 * TONE_HZ) < 1) begin : g_half_check
            $error("chip8_timer_ctrl: CLK_HZ/(2*TONE_HZ) must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prescaler: tick is registered, so it is visible the cycle after the
    // counter sits at DIV-1 on an unpaused edge.
    // ------------------------------------------------------------------
    logic [PW-1:0] pre_reg;
    logic          tick_reg;
    logic          pre_wrap;

    assign pre_wrap = !pause && (pre_reg == PRE_LAST);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= pre_wrap;
            if (!pause) begin
                pre_reg <= pre_wrap ? '0 : pre_reg + 1'b1;
            end
        end
    end

    // The decrement is applied on the edge that closes the tick cycle.
    logic dec_en;
    assign dec_en = tick_reg && !pause;

    // ------------------------------------------------------------------
    // Timers: index 0 = DT, index 1 = ST. A write beats a decrement of the
    // same timer; the other timer is unaffected by the write.
    // ------------------------------------------------------------------
    logic [7:0] timer_reg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_timer
        localparam logic SEL = 1'(gi);
        logic wr_hit;

        assign wr_hit = wr_en && (wr_sel == SEL);

        always_ff @(posedge cpu_clk) begin
            if (reset) begin
                timer_reg[gi] <= 8'd0;
            end else if (wr_hit) begin
                timer_reg[gi] <= wr_data;
            end else if (dec_en && (timer_reg[gi] != 8'd0)) begin
                timer_reg[gi] <= timer_reg[gi] - 8'd1;
            end
        end
    end

    // Only a tick can expire DT; a same-edge DT write suppresses it.
    logic dt_expired_next;
    assign dt_expired_next = dec_en && !(wr_en && !wr_sel) && (timer_reg[0] == 8'd1);

    // ------------------------------------------------------------------
    // Read port and event outputs. Reads see the pre-update timer value.
    // ------------------------------------------------------------------
    logic [7:0] rd_data_reg;
    logic       rd_valid_reg;
    logic       dt_expired_reg;

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            rd_data_reg    <= 8'd0;
            rd_valid_reg   <= 1'b0;
            dt_expired_reg <= 1'b0;
        end else begin
            rd_valid_reg   <= rd_en;
            dt_expired_reg <= dt_expired_next;
            if (rd_en) begin
                rd_data_reg <= rd_sel ? timer_reg[1] : timer_reg[0];
            end
        end
    end

    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign tick       = tick_reg;
    assign dt_expired = dt_expired_reg;
    // Level straight from the register so a fresh ST load sounds at once.
    assign sound_on   = (timer_reg[1] != 8'd0);

`ifdef TIMER_TONE_EN
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

    logic [HW-1:0] tone_cnt_reg;
    logic          tone_reg;

    // Runs regardless of pause; held in its idle state while silent.
    always_ff @(posedge cpu_clk) begin
        if (reset || !sound_on) begin
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
        end else if (tone_cnt_reg == HALF_LAST) begin
            tone_cnt_reg <= '0;
            tone_reg     <= !tone_reg;
        end else begin
            tone_cnt_reg <= tone_cnt_reg + 1'b1;
        end
    end

    // Gate with sound_on so the wave stops in the same cycle ST hits 0.
    assign tone_out = tone_reg && sound_on;
`else
    assign tone_out = 1'b0;
`endif

endmodule
